// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and defaults for the data-memory responder
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE    = 2'b00,
    DMEM_RD_WAIT = 2'b01,
    DMEM_RD_DONE = 2'b10
  } dmem_state_e;

  localparam int          DMEM_DEPTH   = 1024;
  localparam int          DMEM_RD_LAT  = 2;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

endpackage

// File: rtl/data_mem_responder_bank.sv
// rtl/data_mem_responder_bank.sv - four byte-lane arrays, registered lane writes, async word read
module data_mem_responder_bank #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  // Lane g holds data bits [8g+7:8g]; lane 3 is byte offset 0 (big-endian).
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we_i && sel_i[g]) begin
        mem[waddr_i] <= wdata_i[8*g +: 8];
      end
    end

    assign rdata_o[8*g +: 8] = mem[raddr_i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data slave: one-cycle writes, RD_LAT-cycle stalled reads
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = DMEM_DEPTH,
  parameter int          ADDR_W    = 10,
  parameter int          RD_LAT    = DMEM_RD_LAT,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic        stall_req_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              in_range_q, in_range_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              rd_req, wr_req;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_raddr;
  logic [31:0]       bank_rdata;

  assign off      = addr_i - BASE_ADDR;
  assign in_range = ({1'b0, off} < (33'(DEPTH) << 2));
  assign idx      = off[ADDR_W+1:2];
  assign rd_req   = (ce_i == CHIP_ENABLE) && (we_i != WRITE_ENABLE);
  assign wr_req   = (ce_i == CHIP_ENABLE) && (we_i == WRITE_ENABLE);

  data_mem_responder_bank #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .we_i    (bank_we),
    .sel_i   (sel_i),
    .waddr_i (idx),
    .wdata_i (data_i),
    .raddr_i (bank_raddr),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= DMEM_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      data_q     <= ZERO_WORD;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    data_d     = data_q;
    err_d      = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (flush_i) begin
          state_d = DMEM_IDLE;
        end else if (wr_req) begin
          err_d = !in_range;
        end else if (rd_req) begin
          idx_d      = idx;
          in_range_d = in_range;
          cnt_d      = CNT_W'(RD_LAT - 1);
          if (RD_LAT > 1) begin
            state_d = DMEM_RD_WAIT;
          end else begin
            // Single-cycle latency loads straight from the live address.
            state_d = DMEM_RD_DONE;
            data_d  = in_range ? bank_rdata : ZERO_WORD;
            err_d   = !in_range;
          end
        end
      end
      DMEM_RD_WAIT: begin
        if (flush_i) begin
          state_d = DMEM_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DMEM_RD_DONE;
            data_d  = in_range_q ? bank_rdata : ZERO_WORD;
            err_d   = !in_range_q;
          end
        end
      end
      DMEM_RD_DONE: state_d = DMEM_IDLE;
      default:      state_d = DMEM_IDLE;
    endcase
  end

  always_comb begin
    stall_req_o = ((state_q == DMEM_IDLE) && rd_req) || (state_q == DMEM_RD_WAIT);
    bank_we     = (state_q == DMEM_IDLE) && wr_req && in_range && !flush_i;
    bank_raddr  = (state_q == DMEM_IDLE) ? idx : idx_q;
  end

  assign data_o = data_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          USED_W = 64;

  logic        clk = 1'b0;
  logic        rst, ce, we, flush;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  wire  [31:0] dout;
  wire         stall, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_dout;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (10),
    .RD_LAT    (RD_LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce),
    .we_i        (we),
    .addr_i      (addr),
    .sel_i       (sel),
    .data_i      (wdata),
    .flush_i     (flush),
    .data_o      (dout),
    .stall_req_o (stall),
    .err_o       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'(DEPTH * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input bit fl);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; sel = s; wdata = d; flush = fl;
    #1;
    check_eq("wr_stall", 32'(stall), 0);
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; we = 1'b0; flush = 1'b0;
    #1;
    check_eq("wr_err", 32'(err), 32'(!in_rng(a) && !fl));
    if (in_rng(a) && !fl) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; flush = 1'b0;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 16) begin
      n++;
      @(posedge clk);
      @(negedge clk);
      ce = 1'b0;
      #1;
    end
    check_eq({tag, "_stall_cycles"}, n, RD_LAT);
    exp = in_rng(a) ? model[widx(a)] : 32'h0;
    exp_dout = exp;
    check_eq({tag, "_data"}, dout, exp);
    check_eq({tag, "_err"}, 32'(err), 32'(!in_rng(a)));
    @(posedge clk);
    #1;
    check_eq({tag, "_err_clear"}, 32'(err), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev, a;
    int r;
    rst = 1'b1; ce = 1'b0; we = 1'b0; flush = 1'b0;
    addr = '0; sel = '0; wdata = '0; exp_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_data", dout, 0);
    check_eq("rst_err", 32'(err), 0);

    for (int i = 0; i < USED_W; i++) do_write(32'(i * 4), 4'hF, $urandom, 1'b0);

    // Spec scenarios 1..6
    do_write(32'h10, 4'hF, 32'h1234_5678, 1'b0);
    do_read(32'h10, "t1");
    check_eq("t1_const", dout, 32'h1234_5678);
    do_write(32'h11, 4'b0100, 32'hABAB_ABAB, 1'b0);
    do_read(32'h10, "t2");
    check_eq("t2_const", dout, 32'h12AB_5678);

    do_read(32'h1000, "t3_oor");
    do_write(32'h1000, 4'hF, 32'hFFFF_FFFF, 1'b0);
    do_read(32'h0, "t3_word0");

    prev = exp_dout;
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h10;
    #1;
    check_eq("t4_stall1", 32'(stall), 1);
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; flush = 1'b1;
    #1;
    check_eq("t4_stall2", 32'(stall), 1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("t4_stall_drop", 32'(stall), 0);
    check_eq("t4_data_kept", dout, prev);
    check_eq("t4_err", 32'(err), 0);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h10; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; flush = 1'b0;
    #1;
    check_eq("t4_idle_flush_stall", 32'(stall), 0);
    check_eq("t4_idle_flush_data", dout, prev);
    do_write(32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1);
    do_read(32'h10, "t4_wr_flushed");
    check_eq("t4_wr_flushed_const", dout, 32'h12AB_5678);

    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_dout = 32'h0;
    check_eq("t5_stall", 32'(stall), 0);
    check_eq("t5_data", dout, exp_dout);
    do_read(32'h10, "t5_after");
    check_eq("t5_after_const", dout, 32'h12AB_5678);

    do_write(32'h20, 4'hF, 32'hCAFE_F00D, 1'b0);
    do_read(32'h20, "t6_a");
    check_eq("t6_a_const", dout, 32'hCAFE_F00D);
    do_read(32'h24, "t6_b");

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = 32'($urandom_range(0, USED_W - 1) * 4 + $urandom_range(0, 3));
        do_write(a, 4'($urandom), $urandom, 1'b0);
      end else if (r < 8) begin
        a = 32'($urandom_range(0, USED_W - 1) * 4 + $urandom_range(0, 3));
        do_read(a, "rnd_rd");
      end else begin
        a = 32'h1000 + ($urandom & 32'h7FFF_FFF0);
        if (r == 8) do_read(a, "rnd_oor_rd");
        else        do_write(a, 4'hF, $urandom, 1'b0);
      end
    end
    for (int i = 0; i < USED_W; i += 7) do_read(32'(i * 4), "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
